decoder_38: RTL and testbench

Registered 3-to-8 line decoder with active-high one-hot outputs. It converts the 3-bit select formed by A (MSB), B and C (LSB) into exactly one asserted line F0..F7. It serves as the address/select decoder feeding downstream enable logic. Outputs are registered on the single system clock, and reset forces all lines inactive.

---
 rtl/decoder_38_if.sv | 28 ++
 rtl/decoder_38.sv | 51 +++++
 tb/tb_decoder_38.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/decoder_38_if.sv
// Select/decoded-line bundle for the registered 3-to-8 decoder.
// The master drives the select and enable inputs; the slave (the decoder) drives F0..F7 and valid.
`timescale 1ns/1ps
interface decoder_38_if;
  logic en;
  logic A;
  logic B;
  logic C;
  logic F0;
  logic F1;
  logic F2;
  logic F3;
  logic F4;
  logic F5;
  logic F6;
  logic F7;
  logic valid;

  modport master (
    output en, A, B, C,
    input  F0, F1, F2, F3, F4, F5, F6, F7, valid
  );

  modport slave (
    input  en, A, B, C,
    output F0, F1, F2, F3, F4, F5, F6, F7, valid
  );
endinterface

// File: rtl/decoder_38.sv
// Registered 3-to-8 one-hot decoder: {A,B,C} selects one line, en gates all lines.
// Polarity is folded into the flops, so every output comes straight from a register.
`timescale 1ns/1ps
module decoder_38 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  decoder_38_if.slave  bus
);
  localparam int unsigned SEL_W = 3;
  localparam int unsigned LINES = 8;
  localparam logic [LINES-1:0] IDLE = {LINES{OUT_ACTIVE_LOW}};

  logic [SEL_W-1:0] sel;
  logic [LINES-1:0] f_d;
  logic [LINES-1:0] f_q;
  logic             valid_d;
  logic             valid_q;

  // One-hot decode of the select, then applied polarity.
  always_comb begin
    sel     = {bus.A, bus.B, bus.C};
    f_d     = '0;
    valid_d = bus.en;
    if (bus.en) begin
      f_d[sel] = 1'b1;
    end
    f_d = f_d ^ IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q     <= IDLE;
      valid_q <= 1'b0;
    end else begin
      f_q     <= f_d;
      valid_q <= valid_d;
    end
  end

  assign bus.F0    = f_q[0];
  assign bus.F1    = f_q[1];
  assign bus.F2    = f_q[2];
  assign bus.F3    = f_q[3];
  assign bus.F4    = f_q[4];
  assign bus.F5    = f_q[5];
  assign bus.F6    = f_q[6];
  assign bus.F7    = f_q[7];
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_decoder_38.sv
// Bench for decoder_38: an active-high and an active-low instance are driven in lockstep.
// Expected line patterns are queued on drive and popped one edge later.
`timescale 1ns/1ps
module tb_decoder_38;
  logic clk = 1'b0;
  logic rst;

  decoder_38_if bus_h ();
  decoder_38_if bus_l ();

  decoder_38 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_h (.clk(clk), .rst(rst), .bus(bus_h));
  decoder_38 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic [7:0] f;
    logic       v;
  } vec_t;

  typedef struct {
    logic [7:0] f;
    logic       v;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[16];

  function automatic logic [7:0] lines_h();
    return {bus_h.F7, bus_h.F6, bus_h.F5, bus_h.F4, bus_h.F3, bus_h.F2, bus_h.F1, bus_h.F0};
  endfunction

  function automatic logic [7:0] lines_l();
    return {bus_l.F7, bus_l.F6, bus_l.F5, bus_l.F4, bus_l.F3, bus_l.F2, bus_l.F1, bus_l.F0};
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Both instances see the same inputs; the active-low one must show the inverted lines.
  task automatic check_now(input string name, input logic [7:0] exp_f, input logic exp_v);
    cmp({name, "_f_hi"}, lines_h(), exp_f);
    cmp({name, "_v_hi"}, 8'(bus_h.valid), 8'(exp_v));
    cmp({name, "_f_lo"}, lines_l(), ~exp_f);
    cmp({name, "_v_lo"}, 8'(bus_l.valid), 8'(exp_v));
  endtask

  task automatic drive(input logic en, input logic [2:0] sel);
    bus_h.en = en;
    {bus_h.A, bus_h.B, bus_h.C} = sel;
    bus_l.en = en;
    {bus_l.A, bus_l.B, bus_l.C} = sel;
  endtask

  task automatic sample(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", name);
    end else begin
      e = sb.pop_front();
      check_now(name, e.f, e.v);
    end
  endtask

  task automatic step(input logic en, input logic [2:0] sel,
                      input logic [7:0] exp_f, input logic exp_v, input string name);
    exp_t e;
    @(negedge clk);
    drive(en, sel);
    e.f = exp_f;
    e.v = exp_v;
    sb.push_back(e);
    sample(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;

    // sweep, enable gating, wrap-around, simultaneous en/select changes
    tbl[0]  = '{1'b1, 3'd0, 8'h01, 1'b1};
    tbl[1]  = '{1'b1, 3'd1, 8'h02, 1'b1};
    tbl[2]  = '{1'b1, 3'd2, 8'h04, 1'b1};
    tbl[3]  = '{1'b1, 3'd3, 8'h08, 1'b1};
    tbl[4]  = '{1'b1, 3'd4, 8'h10, 1'b1};
    tbl[5]  = '{1'b1, 3'd5, 8'h20, 1'b1};
    tbl[6]  = '{1'b1, 3'd6, 8'h40, 1'b1};
    tbl[7]  = '{1'b1, 3'd7, 8'h80, 1'b1};
    tbl[8]  = '{1'b0, 3'd3, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 3'd3, 8'h08, 1'b1};
    tbl[10] = '{1'b1, 3'd7, 8'h80, 1'b1};
    tbl[11] = '{1'b1, 3'd0, 8'h01, 1'b1};
    tbl[12] = '{1'b1, 3'd7, 8'h80, 1'b1};
    tbl[13] = '{1'b0, 3'd5, 8'h00, 1'b0};
    tbl[14] = '{1'b1, 3'd6, 8'h40, 1'b1};
    tbl[15] = '{1'b1, 3'd4, 8'h10, 1'b1};

    rst = 1'b1;
    drive(1'b1, 3'd2);
    #3;
    check_now("reset_init", 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].sel, tbl[i].f, tbl[i].v, $sformatf("vec%0d", i));
    end

    // latency: a mid-cycle select change must not show before the next edge
    step(1'b1, 3'd2, 8'h04, 1'b1, "lat_pre");
    @(negedge clk);
    drive(1'b1, 3'd6);
    #1;
    check_now("lat_hold", 8'h04, 1'b1);
    e.f = 8'h40;
    e.v = 1'b1;
    sb.push_back(e);
    sample("lat_post");

    // asynchronous reset between edges, inputs during reset ignored
    step(1'b1, 3'd5, 8'h20, 1'b1, "rst_pre");
    @(negedge clk);
    drive(1'b1, 3'd1);
    rst = 1'b1;
    #1;
    check_now("rst_async", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_now("rst_hold", 8'h00, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd5);
    rst = 1'b0;
    e.f = 8'h20;
    e.v = 1'b1;
    sb.push_back(e);
    sample("rst_release");

    step(1'b0, 3'd0, 8'h00, 1'b0, "final_off");
    cmp("sb_empty", 8'(sb.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
